// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive front end.
package eth_rx_pkg;

    typedef logic [1:0] dibit_t;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam dibit_t DIBIT_PRE = 2'b01;
    localparam dibit_t DIBIT_SFD = 2'b11;

    localparam int                   PRE_CNT_W   = 5;
    localparam logic [PRE_CNT_W-1:0] PRE_CNT_MAX = 5'd31;

endpackage

// File: rtl/rmii_rx_sfd_if.sv
// RMII receive pins plus the payload/framing outputs of rmii_rx_sfd.
// slave = the receiver itself, master = the PHY/consumer side.
interface rmii_rx_sfd_if;
    import eth_rx_pkg::*;

    logic   crs_dv_in;
    dibit_t rxd_in;
    dibit_t dibit_out;
    logic   dibit_valid;
    logic   byte_valid;
    logic   frame_start;
    logic   frame_end;
    logic   frame_err;

    modport master (
        output crs_dv_in, rxd_in,
        input  dibit_out, dibit_valid, byte_valid, frame_start, frame_end, frame_err
    );

    modport slave (
        input  crs_dv_in, rxd_in,
        output dibit_out, dibit_valid, byte_valid, frame_start, frame_end, frame_err
    );

endinterface

// File: rtl/rmii_rx_sfd.sv
// RMII receive front end: strips preamble/SFD and emits payload dibits with framing strobes.
// Define RMII_RX_INPUT_REG_EN to add one input register stage (all latencies +1).
module rmii_rx_sfd
    import eth_rx_pkg::*;
#(
    parameter int MIN_PREAMBLE = 8,
    parameter int MAX_BYTES    = 1522
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    rmii_rx_sfd_if.slave rmii
);

    localparam int                    BYTE_CNT_W     = $clog2(MAX_BYTES + 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_LIMIT = BYTE_CNT_W'(MAX_BYTES);
    localparam logic [PRE_CNT_W-1:0]  PRE_MIN        = PRE_CNT_W'(MIN_PREAMBLE);

    logic   w_crs_dv;
    dibit_t w_rxd;

`ifdef RMII_RX_INPUT_REG_EN
    logic   r_crs_dv_q;
    dibit_t r_rxd_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_crs_dv_q <= 1'b0;
            r_rxd_q    <= 2'b00;
        end else begin
            r_crs_dv_q <= rmii.crs_dv_in;
            r_rxd_q    <= rmii.rxd_in;
        end
    end

    assign w_crs_dv = r_crs_dv_q;
    assign w_rxd    = r_rxd_q;
`else
    assign w_crs_dv = rmii.crs_dv_in;
    assign w_rxd    = rmii.rxd_in;
`endif

    state_t                r_state,       w_state;
    logic [PRE_CNT_W-1:0]  r_pre_cnt,     w_pre_cnt;
    logic [1:0]            r_phase,       w_phase;
    logic [BYTE_CNT_W-1:0] r_byte_cnt,    w_byte_cnt;
    dibit_t                r_dibit,       w_dibit;
    logic                  r_dibit_valid, w_dibit_valid;
    logic                  r_byte_pend,   w_byte_pend;
    logic                  r_frame_start, w_frame_start;
    logic                  r_frame_end,   w_frame_end;
    logic                  r_frame_err,   w_frame_err;
    logic                  r_byte_valid;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= IDLE;
            r_pre_cnt     <= '0;
            r_phase       <= '0;
            r_byte_cnt    <= '0;
            r_dibit       <= 2'b00;
            r_dibit_valid <= 1'b0;
            r_byte_pend   <= 1'b0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pre_cnt     <= w_pre_cnt;
            r_phase       <= w_phase;
            r_byte_cnt    <= w_byte_cnt;
            r_dibit       <= w_dibit;
            r_dibit_valid <= w_dibit_valid;
            r_byte_pend   <= w_byte_pend;
            // byte_valid trails the byte's last dibit_valid so it lines up with the assembled byte
            r_byte_valid  <= r_byte_pend;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_frame_err   <= w_frame_err;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_pre_cnt     = r_pre_cnt;
        w_phase       = r_phase;
        w_byte_cnt    = r_byte_cnt;
        w_dibit       = r_dibit;
        w_dibit_valid = 1'b0;
        w_byte_pend   = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_frame_err   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_crs_dv && (w_rxd == DIBIT_PRE)) begin
                    w_state   = PREAMBLE;
                    w_pre_cnt = 5'd1;
                end
            end

            PREAMBLE: begin
                if (!w_crs_dv) begin
                    w_state = IDLE;
                end else if (w_rxd == DIBIT_PRE) begin
                    if (r_pre_cnt != PRE_CNT_MAX) begin
                        w_pre_cnt = r_pre_cnt + 5'd1;
                    end
                end else if ((w_rxd == DIBIT_SFD) && (r_pre_cnt >= PRE_MIN)) begin
                    w_state       = DATA;
                    w_frame_start = 1'b1;
                    w_phase       = 2'd0;
                    w_byte_cnt    = '0;
                end else begin
                    // Too-short preamble or corrupt dibit: nothing was announced, so leave silently
                    w_state = DROP;
                end
            end

            DATA: begin
                if (!w_crs_dv) begin
                    w_state     = IDLE;
                    w_frame_end = 1'b1;
                    w_frame_err = (r_phase != 2'd0) || (r_byte_cnt == '0);
                end else if ((r_phase == 2'd3) && (r_byte_cnt == BYTE_CNT_LIMIT)) begin
                    w_state     = DROP;
                    w_frame_end = 1'b1;
                    w_frame_err = 1'b1;
                end else begin
                    w_dibit_valid = 1'b1;
                    w_dibit       = w_rxd;
                    w_phase       = r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        w_byte_cnt  = r_byte_cnt + 1'b1;
                        w_byte_pend = 1'b1;
                    end
                end
            end

            DROP: begin
                if (!w_crs_dv) begin
                    w_state = IDLE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign rmii.dibit_out   = r_dibit;
    assign rmii.dibit_valid = r_dibit_valid;
    assign rmii.byte_valid  = r_byte_valid;
    assign rmii.frame_start = r_frame_start;
    assign rmii.frame_end   = r_frame_end;
    assign rmii.frame_err   = r_frame_err;

endmodule

// File: tb/tb_rmii_rx_sfd.sv
// Bench for rmii_rx_sfd: a default DUT and a MAX_BYTES=4 DUT share the same RMII stimulus.
`timescale 1ns/1ps
module tb_rmii_rx_sfd;
    import eth_rx_pkg::*;

    localparam int MIN_PRE = 8;
    localparam int MAX_A   = 1522;
    localparam int MAX_B   = 4;
`ifdef RMII_RX_INPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int MAXC = 8192;

    // dv, d[1:0], bv, fs, fe, ferr
    typedef struct packed {
        logic   dv;
        dibit_t d;
        logic   bv;
        logic   fs;
        logic   fe;
        logic   ferr;
    } out_t;

    typedef struct {
        logic       crs;
        dibit_t     rxd;
        out_t       e;
        logic [7:0] b;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   crs = 1'b0;
    dibit_t rxd = 2'b00;

    rmii_rx_sfd_if if_a ();
    rmii_rx_sfd_if if_b ();

    assign if_a.crs_dv_in = crs;
    assign if_a.rxd_in    = rxd;
    assign if_b.crs_dv_in = crs;
    assign if_b.rxd_in    = rxd;

    rmii_rx_sfd #(.MIN_PREAMBLE(MIN_PRE), .MAX_BYTES(MAX_A)) u_dut_a (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rmii     (if_a.slave)
    );

    rmii_rx_sfd #(.MIN_PREAMBLE(MIN_PRE), .MAX_BYTES(MAX_B)) u_dut_b (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rmii     (if_b.slave)
    );

    always #10 clk = ~clk;

    logic       stim_crs [MAXC];
    dibit_t     stim_rxd [MAXC];
    out_t       exp_o    [2][MAXC];
    logic [7:0] exp_byte [2][MAXC];
    logic [7:0] sh       [2];
    dibit_t     pl_q[$];
    vec_t       tbl[$];
    int         ncyc;
    int         n_checks = 0;
    int         n_pass = 0;

    function automatic out_t obs(input int s);
        if (s == 0)
            return out_t'({if_a.dibit_valid, if_a.dibit_out, if_a.byte_valid,
                           if_a.frame_start, if_a.frame_end, if_a.frame_err});
        return out_t'({if_b.dibit_valid, if_b.dibit_out, if_b.byte_valid,
                       if_b.frame_start, if_b.frame_end, if_b.frame_err});
    endfunction

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s cyc %0d: got %h want %h", name, c, act, want);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) begin
            stim_crs[i] = 1'b0;
            stim_rxd[i] = 2'b00;
            for (int s = 0; s < 2; s++) begin
                exp_o[s][i]    = '0;
                exp_byte[s][i] = 8'h00;
            end
        end
        ncyc = 0;
    endtask

    task automatic push(input logic c, input dibit_t d);
        if (ncyc >= MAXC - 8) begin
            $display("FAIL sched_overflow cyc %0d: got %0d want <%0d", ncyc, ncyc, MAXC - 8);
            $fatal(1, "schedule overflow");
        end
        stim_crs[ncyc] = c;
        stim_rxd[ncyc] = d;
        ncyc++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        pl_q.push_back(b[1:0]);
        pl_q.push_back(b[3:2]);
        pl_q.push_back(b[5:4]);
        pl_q.push_back(b[7:6]);
    endtask

    // Expected outputs of one accepted frame whose SFD is stimulus cycle ts.
    task automatic model_frame(input int s, input int ts, input int max_bytes);
        int n;
        int lim;
        bit over;
        n    = pl_q.size();
        lim  = 4 * max_bytes + 3;
        over = 1'b0;
        exp_o[s][ts + LAT].fs = 1'b1;
        for (int i = 0; i < n && !over; i++) begin
            if (i == lim) begin
                exp_o[s][ts + 1 + i + LAT].fe   = 1'b1;
                exp_o[s][ts + 1 + i + LAT].ferr = 1'b1;
                over = 1'b1;
            end else begin
                exp_o[s][ts + 1 + i + LAT].dv = 1'b1;
                exp_o[s][ts + 1 + i + LAT].d  = pl_q[i];
                if (i % 4 == 3) begin
                    exp_o[s][ts + 2 + i + LAT].bv = 1'b1;
                    exp_byte[s][ts + 2 + i + LAT] = {pl_q[i], pl_q[i-1], pl_q[i-2], pl_q[i-3]};
                end
            end
        end
        if (!over) begin
            exp_o[s][ts + 1 + n + LAT].fe   = 1'b1;
            exp_o[s][ts + 1 + n + LAT].ferr = (n % 4 != 0) || (n == 0);
        end
    endtask

    // term: 0 = SFD, 1 = 00 dibit, 2 = 10 dibit, 3 = carrier drops after preamble
    task automatic add_frame(input int z, input int p, input int term, input int g);
        int ts;
        dibit_t tdib;
        repeat (z) push(1'b1, 2'b00);
        repeat (p) push(1'b1, DIBIT_PRE);
        ts = ncyc;
        if (term != 3) begin
            tdib = (term == 0) ? DIBIT_SFD : ((term == 1) ? 2'b00 : 2'b10);
            push(1'b1, tdib);
            foreach (pl_q[i]) push(1'b1, pl_q[i]);
        end
        for (int i = 0; i < g; i++) push(1'b0, dibit_t'($urandom_range(0, 3)));
        if (term == 0 && p >= MIN_PRE) begin
            model_frame(0, ts, MAX_A);
            model_frame(1, ts, MAX_B);
        end
        pl_q.delete();
    endtask

    task automatic check_cycle(input int s, input int c);
        out_t raw, a, e;
        raw = obs(s);
        a   = raw;
        e   = exp_o[s][c];
        if (!e.dv) a.d = e.d;
        check((s == 0) ? "outputs_a" : "outputs_b", c, {1'b0, a}, {1'b0, e});
        if (e.bv && raw.bv)
            check((s == 0) ? "byte_a" : "byte_b", c, sh[s], exp_byte[s][c]);
        if (raw.dv) sh[s] = {raw.d, sh[s][7:2]};
    endtask

    task automatic run_sched();
        for (int c = 0; c < ncyc + LAT + 2; c++) begin
            crs = stim_crs[c];
            rxd = stim_rxd[c];
            @(posedge clk);
            @(negedge clk);
            for (int s = 0; s < 2; s++) check_cycle(s, c);
        end
    endtask

    task automatic drive_cycle(input logic c, input dibit_t d);
        crs = c;
        rxd = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        sh[0] = 8'h00;
        sh[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_a", 0, {1'b0, obs(0)}, 8'h00);
        check("reset_b", 0, {1'b0, obs(1)}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // 28x01 + SFD + 0xA7 then carrier drop
        for (int i = 0; i < 28; i++) tbl.push_back('{1'b1, 2'b01, out_t'(7'b0_00_0000), 8'h00});
        tbl.push_back('{1'b1, 2'b11, out_t'(7'b0_00_0100), 8'h00});
        tbl.push_back('{1'b1, 2'b11, out_t'(7'b1_11_0000), 8'h00});
        tbl.push_back('{1'b1, 2'b01, out_t'(7'b1_01_0000), 8'h00});
        tbl.push_back('{1'b1, 2'b10, out_t'(7'b1_10_0000), 8'h00});
        tbl.push_back('{1'b1, 2'b10, out_t'(7'b1_10_0000), 8'h00});
        tbl.push_back('{1'b0, 2'b00, out_t'(7'b0_00_1010), 8'hA7});
        tbl.push_back('{1'b0, 2'b00, out_t'(7'b0_00_0000), 8'h00});
        clear_sched();
        for (int i = 0; i < tbl.size(); i++) begin
            push(tbl[i].crs, tbl[i].rxd);
            for (int s = 0; s < 2; s++) begin
                exp_o[s][i + LAT]    = tbl[i].e;
                exp_byte[s][i + LAT] = tbl[i].b;
            end
        end
        run_sched();

        clear_sched();
        repeat (4) pl_q.push_back(2'b01);
        add_frame(1, 5, 0, 2);
        push_byte(8'h3C); push_byte(8'h55);
        add_frame(0, MIN_PRE, 0, 2);
        repeat (4) pl_q.push_back(2'b11);
        add_frame(0, MIN_PRE - 1, 0, 1);
        push_byte(8'hE1); pl_q.push_back(2'b10); pl_q.push_back(2'b01);
        add_frame(0, 10, 0, 2);
        for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
        add_frame(0, 12, 0, 3);
        add_frame(0, 9, 0, 1);
        push_byte(8'h99);
        add_frame(2, 10, 1, 1);
        push_byte(8'h66);
        add_frame(0, 10, 2, 1);
        add_frame(0, 10, 3, 1);
        push_byte(8'hC3);
        add_frame(0, 40, 0, 2);
        run_sched();

        // Asynchronous reset in the middle of a frame, away from any clock edge
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, DIBIT_PRE);
        drive_cycle(1'b1, DIBIT_SFD);
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, dibit_t'(i % 4));
        check("pre_reset_dv_a", 0, {7'b0, if_a.dibit_valid}, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_a", 0, {1'b0, obs(0)}, 8'h00);
        check("async_reset_b", 0, {1'b0, obs(1)}, 8'h00);
        crs = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 2'b00);
            check("post_reset_a", i, {1'b0, obs(0)}, 8'h00);
            check("post_reset_b", i, {1'b0, obs(1)}, 8'h00);
        end

        clear_sched();
        push_byte(8'hA7); push_byte(8'h5A);
        add_frame(0, 12, 0, 2);
        for (int f = 0; f < 40; f++) begin
            int z, p, term, n, g;
            z    = $urandom_range(0, 3);
            p    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 40);
            term = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
            n    = $urandom_range(0, 28);
            g    = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) pl_q.push_back(dibit_t'($urandom_range(0, 3)));
            add_frame(z, p, term, g);
        end
        run_sched();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
